line_sched: RTL

- Round-robin scheduler that shares one line-drawing engine between NREQ requesters.
- Each requester is, for example, a missile track, cursor or HUD overlay. It offers one segment (start and end point, 8-bit coordinates); the scheduler grants one requester, latches the segment and launches the engine with a one-cycle go.
- Coordinates are held stable while the engine is busy. The owner gets a completion pulse when the line finishes.
- A watchdog flags an engine that never starts or never finishes.

---
 rtl/line_sched_if.sv | 29 ++
 rtl/line_sched.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/line_sched_if.sv
// Requester and line-engine signal bundle for line_sched.
// The scheduler sits on the slave modport; requesters and the engine model sit on master.
interface line_sched_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_stax;
    logic [8*NREQ-1:0] req_stay;
    logic [8*NREQ-1:0] req_endx;
    logic [8*NREQ-1:0] req_endy;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   req_done;
    logic              ld_go;
    logic              ld_busy;
    logic [7:0]        ld_stax;
    logic [7:0]        ld_stay;
    logic [7:0]        ld_endx;
    logic [7:0]        ld_endy;

    modport slave (
        input  req_valid, req_stax, req_stay, req_endx, req_endy, ld_busy,
        output req_ready, req_done, ld_go, ld_stax, ld_stay, ld_endx, ld_endy
    );

    modport master (
        output req_valid, req_stax, req_stay, req_endx, req_endy, ld_busy,
        input  req_ready, req_done, ld_go, ld_stax, ld_stay, ld_endx, ld_endy
    );
endinterface

// File: rtl/line_sched.sv
// Round-robin scheduler sharing one line-drawing engine between NREQ requesters,
// with a start/draw watchdog.
//   state     | meaning
//   IDLE      | waiting for a valid request while the engine is idle
//   LAUNCH    | ld_go pulse, segment latched
//   WAIT_BUSY | waiting for the engine to raise busy
//   DRAW      | engine drawing, waiting for busy to fall
//   FIN       | completion pulse to the owner
module line_sched #(
    parameter int NREQ     = 4,
    parameter int IDW      = 2,
    parameter int START_TO = 4,
    parameter int DRAW_TO  = 600
) (
    input  logic            clk,
    input  logic            rst_n,
    line_sched_if.slave     bus,
    input  logic            clr_err_i,
    output logic            active_o,
    output logic [IDW-1:0]  grant_id_o,
    output logic            timeout_err_o
);
    localparam int             CW        = 10;
    localparam logic [CW-1:0]  START_LIM = CW'(START_TO - 1);
    localparam logic [CW-1:0]  DRAW_LIM  = CW'(DRAW_TO - 1);
    localparam logic [IDW:0]   NREQ_W    = (IDW+1)'(NREQ);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, DRAW, FIN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [IDW-1:0]  grant_q, grant_d;
    logic [7:0]      stax_q, stax_d, stay_q, stay_d, endx_q, endx_d, endy_q, endy_d;
    logic            err_q, err_d;
    logic            timeout_c;
    logic            found_c;
    logic            grant_c;
    logic [IDW-1:0]  win_c;
    logic [IDW:0]    cand_c;

    // Search upward from the last grant, wrapping at NREQ.
    always_comb begin
        found_c = 1'b0;
        win_c   = grant_q;
        cand_c  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_c = {1'b0, grant_q} + (IDW+1)'(k);
            if (cand_c >= NREQ_W) cand_c = cand_c - NREQ_W;
            if (!found_c && bus.req_valid[cand_c[IDW-1:0]]) begin
                found_c = 1'b1;
                win_c   = cand_c[IDW-1:0];
            end
        end
    end

    // The engine has no reset, so a still-busy engine blocks any new grant.
    assign grant_c = (state_q == IDLE) && found_c && !bus.ld_busy && rst_n;
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        stax_d    = stax_q;
        stay_d    = stay_q;
        endx_d    = endx_q;
        endy_d    = endy_q;
        timeout_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_c) begin
                    grant_d = win_c;
                    stax_d  = bus.req_stax[8*win_c +: 8];
                    stay_d  = bus.req_stay[8*win_c +: 8];
                    endx_d  = bus.req_endx[8*win_c +: 8];
                    endy_d  = bus.req_endy[8*win_c +: 8];
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.ld_busy) begin
                    cnt_d   = '0;
                    state_d = DRAW;
                end else if (cnt_q >= START_LIM) begin
                    timeout_c = 1'b1;
                    state_d   = FIN;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            DRAW: begin
                if (!bus.ld_busy) begin
                    state_d = FIN;
                end else if (cnt_q >= DRAW_LIM) begin
                    timeout_c = 1'b1;
                    state_d   = FIN;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A timeout in the same cycle as clr_err keeps the flag set.
    assign err_d = timeout_c ? 1'b1 : (clr_err_i ? 1'b0 : err_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grant_q <= IDW'(NREQ - 1);
            stax_q  <= '0;
            stay_q  <= '0;
            endx_q  <= '0;
            endy_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            stax_q  <= stax_d;
            stay_q  <= stay_d;
            endx_q  <= endx_d;
            endy_q  <= endy_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready  = grant_c ? (NREQ'(1) << win_c) : '0;
    assign bus.req_done   = (state_q == FIN) ? (NREQ'(1) << grant_q) : '0;
    assign bus.ld_go      = (state_q == LAUNCH);
    assign bus.ld_stax    = stax_q;
    assign bus.ld_stay    = stay_q;
    assign bus.ld_endx    = endx_q;
    assign bus.ld_endy    = endy_q;
    assign active_o       = (state_q != IDLE);
    assign grant_id_o     = grant_q;
    assign timeout_err_o  = err_q;
endmodule
